// File: rtl/mem_resp_pkg.sv
`default_nettype none
// ============================================================================
// mem_resp_pkg : shared constants and types for the memory response port
// Revision     : 1.0
// ============================================================================
package mem_resp_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic C_ERR_NONE = 1'b0;
  localparam logic C_ERR_ADDR = 1'b1;

  localparam int unsigned C_BYTE_W = 8;
  localparam int unsigned C_LANES  = 4;
  localparam int unsigned C_CNT_W  = 4;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  // Misaligned, or any byte-address bit above the word index is set.
  function automatic logic addr_is_bad(input logic [31:0] addr, input int unsigned aw);
    logic [31:0] hi_mask;
    hi_mask = 32'hFFFF_FFFF << (aw + 2);
    return (addr[1:0] != 2'b00) || ((addr & hi_mask) != 32'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_resp_port_wait_ctr.sv
`default_nettype none
// ============================================================================
// wait_ctr : loadable down-counter; done while the count sits at zero
// Revision : 1.0
// ============================================================================
module wait_ctr
  import mem_resp_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [C_CNT_W-1:0] load_val,
  input  logic               en,
  output logic               done
);

  logic [C_CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/mem_resp_port.sv
`default_nettype none
// ============================================================================
// mem_resp_port : word memory target with programmable wait states
// Revision      : 1.0
// ============================================================================
module mem_resp_port
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned AW          = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [C_CNT_W-1:0] C_WAIT = C_CNT_W'(WAIT_CYCLES);

  logic [1:0]  r_state;
  req_t        r_req;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;
  logic [31:0] r_mem [DEPTH];

  logic          w_accept;
  logic          w_done;
  logic          w_access;
  logic          w_bad;
  logic          w_wr;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_bmask;

  assign req_ready = reset && (r_state == S_IDLE);
  assign w_accept  = req_valid && req_ready;
  assign w_access  = (r_state == S_WAIT) && w_done;
  assign w_bad     = addr_is_bad(r_req.addr, AW);
  assign w_idx     = r_req.addr[AW+1:2];
  // A reset on the access edge drops the pending write.
  assign w_wr      = reset && w_access && r_req.we && !w_bad;

  for (genvar g = 0; g < C_LANES; g++) begin : g_lane
    assign w_bmask[g*C_BYTE_W +: C_BYTE_W] = {C_BYTE_W{r_req.be[g]}};
  end

  // The counter is loaded on acceptance; WAIT ends on the cycle it reads zero.
  wait_ctr u_wait_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (w_accept),
    .load_val (C_WAIT),
    .en       (r_state == S_WAIT),
    .done     (w_done)
  );

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_req.we    <= req_we;
      r_req.addr  <= req_addr;
      r_req.be    <= req_be;
      r_req.wdata <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[w_idx] <= (r_mem[w_idx] & ~w_bmask) | (r_req.wdata & w_bmask);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= C_ERR_NONE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_done) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_bad ? C_ERR_ADDR : C_ERR_NONE;
            r_rsp_rdata <= (w_bad || r_req.we) ? 32'd0 : r_mem[w_idx];
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= C_ERR_NONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_resp_port.sv
`default_nettype none
// ============================================================================
// tb_mem_resp_port : directed checks of mem_resp_port (WAIT_CYCLES 2 and 0)
// Revision         : 1.0
// ============================================================================
module tb_mem_resp_port;
  import mem_resp_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        z_req_valid, z_req_ready, z_req_we;
  logic [31:0] z_req_addr, z_req_wdata;
  logic [3:0]  z_req_be;
  logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [31:0] z_rsp_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] rd;
  logic        er;
  int          lat;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_resp_port #(.DEPTH(256), .AW(8), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  mem_resp_port #(.DEPTH(256), .AW(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_be(z_req_be), .req_wdata(z_req_wdata),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request and return #1 after the edge that accepts it.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be; req_wdata = wd;
    while (req_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: req_ready=%b, expected 1", req_ready);
    end
    @(posedge clk); #1;
    // Scramble the inputs to show the captured fields are held.
    req_valid = 1'b0; req_we = ~we; req_addr = 32'hFFFF_FFFF; req_be = 4'hF;
    req_wdata = 32'h0BAD_0BAD;
  endtask

  task automatic wait_rsp(output logic [31:0] r, output logic e, output int l);
    l = 0;
    while (rsp_valid !== 1'b1 && l < 40) begin
      @(posedge clk); #1;
      l++;
    end
    r = rsp_rdata;
    e = rsp_err;
  endtask

  task automatic do_xact(input string tag, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] r;
    logic        e;
    int          l;
    issue(we, addr, be, wd);
    wait_rsp(r, e, l);
    chk({tag, "_lat"}, 32'(l), 32'd3);
    chk({tag, "_rdata"}, r, exp_rd);
    chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    @(posedge clk); #1;
    chk({tag, "_hs_valid"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc [4];
    int rv  [4];
    int na = 0;
    int nr = 0;
    logic a;
    logic prev_rv;

    reset = 1'b0; rsp_ready = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_be = '0; req_wdata = '0;
    z_rsp_ready = 1'b1;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_be = '0; z_req_wdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
    chk("rst_state",     {30'd0, dut.r_state}, {30'd0, S_IDLE});
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_req_ready", {31'd0, req_ready}, 32'd1);

    // Full write, read back, byte-lane write, empty byte-enable write
    do_xact("wr_full", 1'b1, 32'h10, 4'hF,    32'hDEAD_BEEF, 32'd0,          1'b0);
    do_xact("rd_full", 1'b0, 32'h10, 4'h0,    32'd0,         32'hDEAD_BEEF,  1'b0);
    do_xact("wr_b0",   1'b1, 32'h10, 4'b0001, 32'h0000_00AA, 32'd0,          1'b0);
    do_xact("rd_b0",   1'b0, 32'h10, 4'h0,    32'd0,         32'hDEAD_BEAA,  1'b0);
    do_xact("wr_be0",  1'b1, 32'h10, 4'b0000, 32'h1234_5678, 32'd0,          1'b0);
    do_xact("rd_be0",  1'b0, 32'h10, 4'h0,    32'd0,         32'hDEAD_BEAA,  1'b0);

    // Backpressure on a read of 0x10
    rsp_ready = 1'b0;
    issue(1'b0, 32'h10, 4'h0, 32'd0);
    wait_rsp(rd, er, lat);
    chk("bp_lat",   32'(lat), 32'd3);
    chk("bp_rdata", rd, 32'hDEAD_BEAA);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'h0; req_wdata = 32'd0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_hold_rdata", rsp_rdata, 32'hDEAD_BEAA);
      chk("bp_hold_ready", {31'd0, req_ready}, 32'd0);
    end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_hs_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_hs_ready", {31'd0, req_ready}, 32'd1);
    chk("bp_hs_state", {30'd0, dut.r_state}, {30'd0, S_IDLE});
    @(posedge clk); #1;
    chk("bp_next_acc", {31'd0, req_ready}, 32'd0);
    req_valid = 1'b0;
    wait_rsp(rd, er, lat);
    chk("bp_next_lat",   32'(lat), 32'd3);
    chk("bp_next_rdata", rd, 32'hDEAD_BEAA);
    @(posedge clk); #1;

    // Address errors
    do_xact("err_mis", 1'b0, 32'h12,        4'h0, 32'd0,         32'd0,         1'b1);
    do_xact("wr_w0",   1'b1, 32'h0,         4'hF, 32'hCAFE_F00D, 32'd0,         1'b0);
    do_xact("err_oor", 1'b1, 32'h400,       4'hF, 32'h5555_5555, 32'd0,         1'b1);
    do_xact("rd_w0",   1'b0, 32'h0,         4'h0, 32'd0,         32'hCAFE_F00D, 1'b0);
    do_xact("err_hi",  1'b0, 32'h8000_0010, 4'h0, 32'd0,         32'd0,         1'b1);

    // Reset during WAIT of a write
    do_xact("wr_w20", 1'b1, 32'h20, 4'hF, 32'h1111_1111, 32'd0, 1'b0);
    issue(1'b1, 32'h20, 4'hF, 32'hFFFF_FFFF);
    chk("mid_state_wait", {30'd0, dut.r_state}, {30'd0, S_WAIT});
    reset = 1'b0;
    @(posedge clk); #1;
    chk("mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_state",     {30'd0, dut.r_state}, {30'd0, S_IDLE});
    chk("mid_req_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk); reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_quiet", {31'd0, rsp_valid}, 32'd0);
    do_xact("mid_rd", 1'b0, 32'h20, 4'h0, 32'd0, 32'h1111_1111, 1'b0);

    // Zero-wait instance: one write, then back-to-back reads
    @(negedge clk);
    chk("z_ready", {31'd0, z_req_ready}, 32'd1);
    z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = 32'h8; z_req_be = 4'hF;
    z_req_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    z_req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("z_wr_done_valid", {31'd0, z_rsp_valid}, 32'd0);
    chk("z_wr_done_ready", {31'd0, z_req_ready}, 32'd1);
    z_req_valid = 1'b1; z_req_we = 1'b0; z_req_addr = 32'h8; z_req_be = 4'h0;
    prev_rv = z_rsp_valid;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      a = z_req_valid && z_req_ready;
      @(posedge clk); #1;
      if (a && na < 4) begin
        acc[na] = cyc;
        na++;
      end
      if (z_rsp_valid && !prev_rv && nr < 4) begin
        rv[nr] = cyc;
        nr++;
        chk("z_rd_rdata", z_rsp_rdata, 32'h1234_5678);
        chk("z_rd_err",   {31'd0, z_rsp_err}, 32'd0);
      end
      prev_rv = z_rsp_valid;
    end
    z_req_valid = 1'b0;
    chk("z_accept_count", 32'(na), 32'd4);
    chk("z_rsp_count",    32'(nr), 32'd4);
    for (int k = 0; k < nr && k < na; k++) begin
      chk("z_latency", 32'(rv[k] - acc[k]), 32'd1);
    end
    for (int k = 0; k + 1 < na; k++) begin
      chk("z_accept_period", 32'(acc[k+1] - acc[k]), 32'd3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
